// File: rtl/mem_stage_sramlike_pkg.sv
// Shared definitions for the EX/MEM/WB pipeline: access sizes, MEM-stage states, reset PC.
package mem_stage_sramlike_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StHold,
      StDrain
   } mem_state_e;

endpackage

// File: rtl/mem_stage_sramlike_if.sv
// Split-transaction SRAM-like data bus: request handshake on addr_ok, response on data_ok.
interface mem_stage_sramlike_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane helper: store strobes/replicated data, alignment check, load lane extraction.
module mem_lane_align
   import mem_stage_sramlike_pkg::*;
(
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_off,
   input  logic [31:0] req_wsrc,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        misaligned,
   input  logic [1:0]  rsp_size,
   input  logic [1:0]  rsp_off,
   input  logic        rsp_unsigned,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);

   logic [15:0] lane;

   always_comb begin
      wstrb      = 4'b1111;
      wdata      = req_wsrc;
      misaligned = 1'b0;
      case (req_size)
         SZ_B: begin
            wstrb = 4'b0001 << req_off;
            wdata = {4{req_wsrc[7:0]}};
         end
         SZ_H: begin
            wstrb      = 4'b0011 << req_off;
            wdata      = {2{req_wsrc[15:0]}};
            misaligned = req_off[0];
         end
         default: misaligned = (req_off != 2'b00);
      endcase
   end

   assign lane = 16'(rdata >> {rsp_off, 3'b000});

   always_comb begin
      load_data = rdata;
      case (rsp_size)
         SZ_B:    load_data = {{24{~rsp_unsigned & lane[7]}}, lane[7:0]};
         SZ_H:    load_data = {{16{~rsp_unsigned & lane[15]}}, lane[15:0]};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_sramlike.sv
// MEM pipeline stage driving a split-transaction SRAM-like bus, with flush and response draining.
module mem_stage_sramlike
   import mem_stage_sramlike_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned DEST_W     = 5,
   parameter int unsigned WAIT_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_pc,
   input  logic [31:0]           in_result,
   input  logic                  in_mem_en,
   input  logic                  in_mem_we,
   input  logic [1:0]            in_size,
   input  logic                  in_unsigned,
   input  logic [31:0]           in_rkd,
   input  logic                  in_gr_we,
   input  logic [DEST_W-1:0]     in_dest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_pc,
   output logic [31:0]           out_result,
   output logic                  out_gr_we,
   output logic [DEST_W-1:0]     out_dest,
   output logic                  out_ale,
   mem_stage_sramlike_if.master  bus,
   output logic [WAIT_CNT_W-1:0] wait_cycles
);

   mem_state_e state_q, state_d, accept_state;
   logic       kill_q, kill_d;
   logic [WAIT_CNT_W-1:0] wait_d;

   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  size_q;
   logic        we_q, uns_q;

   logic        accept, capture, misaligned, req_active;
   logic [3:0]  wstrb_new;
   logic [31:0] wdata_new, load_data;

   mem_lane_align u_align (
      .req_size     (in_size),
      .req_off      (in_result[1:0]),
      .req_wsrc     (in_rkd),
      .wstrb        (wstrb_new),
      .wdata        (wdata_new),
      .misaligned   (misaligned),
      .rsp_size     (size_q),
      .rsp_off      (addr_q[1:0]),
      .rsp_unsigned (uns_q),
      .rdata        (bus.data_rdata),
      .load_data    (load_data)
   );

   assign in_ready     = ((state_q == StIdle) || (state_q == StHold && out_ready)) && !flush;
   assign accept       = in_valid && in_ready;
   assign accept_state = (in_mem_en && !misaligned) ? StReq : StHold;
   assign out_valid    = (state_q == StHold);
   assign req_active   = (state_q == StReq);

   // Bus outputs are gated so they read as zero whenever no request is pending.
   assign bus.data_req   = req_active;
   assign bus.data_wr    = req_active & we_q;
   assign bus.data_size  = req_active ? size_q  : 2'b00;
   assign bus.data_addr  = req_active ? addr_q  : 32'h0;
   assign bus.data_wstrb = req_active ? wstrb_q : 4'h0;
   assign bus.data_wdata = req_active ? wdata_q : 32'h0;

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      capture = 1'b0;
      wait_d  = wait_cycles;
      unique case (state_q)
         StIdle: if (accept) state_d = accept_state;
         StHold: begin
            if (flush)          state_d = StIdle;
            else if (out_ready) state_d = accept ? accept_state : StIdle;
         end
         StReq: begin
            // A flush seen while the request is pending must survive until addr_ok.
            kill_d = kill_q | flush;
            if (bus.data_addr_ok) begin
               if (kill_q || flush) begin
                  state_d = bus.data_data_ok ? StIdle : StDrain;
               end else begin
                  state_d = bus.data_data_ok ? StHold : StWait;
                  capture = bus.data_data_ok;
               end
            end
         end
         StWait: begin
            if (bus.data_data_ok) begin
               state_d = flush ? StIdle : StHold;
               capture = !flush;
            end else if (flush) begin
               state_d = StDrain;
            end
         end
         StDrain: if (bus.data_data_ok) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (accept) kill_d = 1'b0;
      if (accept && accept_state == StReq) begin
         wait_d = '0;
      end else if ((state_q == StReq || state_q == StWait) && wait_cycles != '1) begin
         wait_d = wait_cycles + WAIT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         kill_q      <= 1'b0;
         wait_cycles <= '0;
         out_pc      <= RESET_PC;
         out_result  <= 32'h0;
         out_gr_we   <= 1'b0;
         out_dest    <= '0;
         out_ale     <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         size_q      <= 2'b00;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         kill_q      <= kill_d;
         wait_cycles <= wait_d;
         if (accept) begin
            out_pc     <= in_pc;
            out_result <= in_result;
            out_gr_we  <= in_gr_we && !(in_mem_en && misaligned);
            out_dest   <= in_dest;
            out_ale    <= in_mem_en && misaligned;
            addr_q     <= in_result;
            wdata_q    <= wdata_new;
            wstrb_q    <= wstrb_new;
            size_q     <= in_size;
            we_q       <= in_mem_we;
            uns_q      <= in_unsigned;
         end
         if (capture && !we_q) out_result <= load_data;
      end
   end

endmodule

// File: tb/tb_mem_stage_sramlike.sv
// Directed and randomized bench for mem_stage_sramlike with a bus responder and reference model.
module tb_mem_stage_sramlike;

   logic        clk = 1'b0;
   logic        resetn, flush, in_valid, in_ready;
   logic [31:0] in_pc, in_result, in_rkd;
   logic        in_mem_en, in_mem_we, in_unsigned, in_gr_we;
   logic [1:0]  in_size;
   logic [4:0]  in_dest;
   logic        out_valid, out_ready, out_gr_we, out_ale;
   logic [31:0] out_pc, out_result;
   logic [4:0]  out_dest;
   logic [7:0]  wait_cycles;
   int          errors = 0;
   int          checks = 0;

   mem_stage_sramlike_if bus ();

   mem_stage_sramlike #(
      .RESET_PC   (32'h1c000000),
      .DEST_W     (5),
      .WAIT_CNT_W (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_result   (in_result),
      .in_mem_en   (in_mem_en),
      .in_mem_we   (in_mem_we),
      .in_size     (in_size),
      .in_unsigned (in_unsigned),
      .in_rkd      (in_rkd),
      .in_gr_we    (in_gr_we),
      .in_dest     (in_dest),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_result  (out_result),
      .out_gr_we   (out_gr_we),
      .out_dest    (out_dest),
      .out_ale     (out_ale),
      .bus         (bus.master),
      .wait_cycles (wait_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] pc, input logic [31:0] res, input logic mem_en,
                         input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] rkd, input logic gr_we, input logic [4:0] dest);
      in_pc = pc; in_result = res; in_mem_en = mem_en; in_mem_we = we; in_size = sz;
      in_unsigned = uns; in_rkd = rkd; in_gr_we = gr_we; in_dest = dest;
   endtask

   // Issues one instruction from IDLE, plays the bus with the given latencies, checks WB payload.
   // a_lat: REQ cycles including the addr_ok cycle; d_lat: further cycles to data_ok (0 = same).
   task automatic run_op(input logic [31:0] pc, input logic [31:0] res, input logic mem_en,
                         input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] rkd, input logic gr_we, input logic [4:0] dest,
                         input int a_lat, input int d_lat, input logic [31:0] rdata,
                         input bit use_want, input logic [31:0] want);
      int          off, v, exp_wait;
      bit          mis;
      logic [31:0] exp_res, exp_wd;
      logic [3:0]  exp_strb;
      off = int'(res[1:0]);
      mis = mem_en && ((sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0));
      exp_res = res;
      if (mem_en && !mis && !we) begin
         if (sz == 2'd0) begin
            v = int'((rdata >> (8 * off)) & 32'hFF);
            if (!uns && v >= 128) v -= 256;
         end else if (sz == 2'd1) begin
            v = int'((rdata >> (8 * off)) & 32'hFFFF);
            if (!uns && v >= 32768) v -= 65536;
         end else begin
            v = int'(rdata);
         end
         exp_res = 32'(v);
      end
      exp_strb = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << off) : 4'hF;
      exp_wd = (sz == 2'd0) ? {24'h0, rkd[7:0]} * 32'h01010101 :
               (sz == 2'd1) ? {16'h0, rkd[15:0]} * 32'h00010001 : rkd;
      exp_wait = (a_lat + d_lat > 255) ? 255 : a_lat + d_lat;

      set_op(pc, res, mem_en, we, sz, uns, rkd, gr_we, dest);
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("accept_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      if (mem_en && !mis) begin
         for (int i = 1; i <= a_lat; i++) begin
            bus.data_addr_ok = (i == a_lat);
            bus.data_data_ok = (i == a_lat) && (d_lat == 0);
            bus.data_rdata   = rdata;
            #1 chk("req_asserted", bus.data_req, 1'b1);
            if (i == 1) begin
               chk("req_addr", bus.data_addr, res);
               chk("req_wr", bus.data_wr, we);
               chk("req_size", bus.data_size, sz);
               chk("req_wstrb", bus.data_wstrb, exp_strb);
               if (we) chk("req_wdata", bus.data_wdata, exp_wd);
            end
            step();
            bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
         end
         for (int j = 1; j <= d_lat; j++) begin
            bus.data_data_ok = (j == d_lat);
            bus.data_rdata   = rdata;
            #1 chk("wait_no_valid", out_valid, 1'b0);
            chk("wait_no_req", bus.data_req, 1'b0);
            step();
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = $urandom;
         end
      end
      #1 chk("no_req_in_hold", bus.data_req, 1'b0);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", out_result, exp_res);
      chk("hold_pc", out_pc, pc);
      chk("hold_dest", out_dest, dest);
      chk("hold_gr_we", out_gr_we, gr_we && !mis);
      chk("hold_ale", out_ale, mis);
      if (mem_en && !mis) chk("wait_cycles", wait_cycles, 32'(exp_wait));
      if (use_want) chk("directed_result", out_result, want);
      step();
      chk("back_to_idle", out_valid, 1'b0);
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_op(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 5'd0);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
      #12;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_pc", out_pc, 32'h1c000000);
      chk("rst_result", out_result, 32'h0);
      chk("rst_dest_gr_ale", {out_dest, out_gr_we, out_ale}, 32'h0);
      chk("rst_wait", wait_cycles, 32'h0);
      chk("rst_bus", {bus.data_req, bus.data_wr, bus.data_size, bus.data_wstrb}, 32'h0);
      chk("rst_bus_data", bus.data_addr | bus.data_wdata, 32'h0);
      resetn = 1'b1;
      step();

      // Stray response while idle must be ignored.
      bus.data_data_ok = 1'b1;
      step();
      bus.data_data_ok = 1'b0;
      #1 chk("stray_ok_ignored", out_valid, 1'b0);

      run_op(32'h1c000010, 32'h12345678, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd3,
             0, 0, 32'h0, 1'b1, 32'h12345678);
      run_op(32'h1c000014, 32'h00001003, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 5'd4,
             2, 3, 32'h80FFFFFF, 1'b1, 32'hFFFFFF80);
      run_op(32'h1c000018, 32'h00001003, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1, 5'd5,
             2, 3, 32'h80FFFFFF, 1'b1, 32'h00000080);
      run_op(32'h1c00001c, 32'h00002002, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0000BEEF, 1'b0, 5'd0,
             1, 1, 32'h0, 1'b0, 32'h0);
      run_op(32'h1c000020, 32'h00003001, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd6,
             0, 0, 32'h0, 1'b0, 32'h0);
      run_op(32'h1c000024, 32'h00004002, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 1'b1, 5'd7,
             1, 0, 32'h7FFF1234, 1'b1, 32'h00007FFF);
      run_op(32'h1c000028, 32'h00005000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd8,
             1, 300, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);

      // Flush in WAIT; the orphaned response arrives four cycles later.
      set_op(32'h1c000030, 32'h00006000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd9);
      in_valid = 1'b1;
      step();
      bus.data_addr_ok = 1'b1;
      step();
      bus.data_addr_ok = 1'b0;
      flush = 1'b1;
      #1 chk("flush_wait_ready", in_ready, 1'b0);
      step();
      flush = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         bus.data_data_ok = (k == 4);
         #1 chk("drain_ready", in_ready, 1'b0);
         chk("drain_valid", out_valid, 1'b0);
         step();
      end
      bus.data_data_ok = 1'b0; in_valid = 1'b0;
      #1 chk("after_drain_ready", in_ready, 1'b1);
      run_op(32'h1c000034, 32'h00006004, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd10,
             1, 2, 32'h0BADBEEF, 1'b1, 32'h0BADBEEF);

      // Flush while the request is still pending: req holds until addr_ok, then drains.
      set_op(32'h1c000038, 32'h00007000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd11);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0; bus.data_addr_ok = 1'b1;
      #1 chk("req_survives_flush", bus.data_req, 1'b1);
      step();
      bus.data_addr_ok = 1'b0;
      #1 chk("drain_no_req", bus.data_req, 1'b0);
      step();
      bus.data_data_ok = 1'b1;
      #1 chk("drain_no_valid", out_valid, 1'b0);
      step();
      bus.data_data_ok = 1'b0;
      #1 chk("drain_done_valid", out_valid, 1'b0);
      chk("drain_done_ready", in_ready, 1'b1);

      // Back-pressure in HOLD, then back-to-back accept.
      out_ready = 1'b0;
      set_op(32'h1c000040, 32'hA5A5A5A5, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 5'd12);
      in_valid = 1'b1;
      step();
      set_op(32'h1c000044, 32'h5A5A5A5A, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 5'd13);
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_valid", out_valid, 1'b1);
         chk("bp_result", out_result, 32'hA5A5A5A5);
         chk("bp_ready", in_ready, 1'b0);
         step();
      end
      out_ready = 1'b1;
      #1 chk("b2b_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      #1 chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_result", out_result, 32'h5A5A5A5A);
      chk("b2b_pc", out_pc, 32'h1c000044);
      step();
      chk("b2b_idle", out_valid, 1'b0);

      // Flush in HOLD, then flush overriding an accept in IDLE.
      out_ready = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b1;
      #1 chk("flush_hold_ready", in_ready, 1'b0);
      step();
      #1 chk("flush_hold_drop", out_valid, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("flush_blocks_accept", in_ready, 1'b0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1 chk("flush_accept_none", out_valid | bus.data_req, 1'b0);

      for (int n = 0; n < 24; n++) begin
         run_op($urandom, $urandom, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom_range(1, 3), $urandom_range(0, 3), $urandom, 1'b0, 32'h0);
      end

      // Asynchronous reset in the middle of a request.
      set_op(32'h1c000050, 32'h00008000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd14);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #1 chk("pre_reset_req", bus.data_req, 1'b1);
      resetn = 1'b0;
      #1 chk("async_rst_req", bus.data_req, 1'b0);
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_pc", out_pc, 32'h1c000000);
      #2 resetn = 1'b1;
      step();
      run_op(32'h1c000060, 32'h00009001, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1, 5'd15,
             1, 1, 32'h0000AB00, 1'b1, 32'h000000AB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_sramlike.md
Name: mem_stage_sramlike

Overview:
- Parametrised successor to the single-cycle SRAM memory stage.
- Sits between EX and WB. Drives a split-transaction SRAM-like data bus: request accepted by `addr_ok`, data returned by `data_ok`. Multi-cycle bus latency and back-pressure are tolerated.
- Adds load sign/zero extension, a misalignment (ALE) flag, and pipeline flush with safe draining of orphaned bus responses.

Parameters:
- RESET_PC, 32'h1c000000, reset value of out_pc.
- DEST_W, 5, width of the register destination field.
- WAIT_CNT_W, 8, width of the bus-wait cycle counter; counter saturates at its maximum.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard held and incoming instruction
- in_valid  in  1  EX has an instruction
- in_ready  out  1  stage can accept
- in_pc  in  32  instruction PC
- in_result  in  32  ALU result / effective address
- in_mem_en  in  1  memory op
- in_mem_we  in  1  store (valid when in_mem_en)
- in_size  in  2  0=byte 1=half 2=word
- in_unsigned  in  1  zero-extend load
- in_rkd  in  32  store data
- in_gr_we  in  1  writes register
- in_dest  in  DEST_W  destination register
- out_valid  out  1  WB payload valid
- out_ready  in  1  WB can accept
- out_pc  out  32  PC
- out_result  out  32  final result (load data or passthrough)
- out_gr_we  out  1  register write enable, forced 0 when ALE
- out_dest  out  DEST_W  destination
- out_ale  out  1  misaligned access
- data_req  out  1  bus request
- data_wr  out  1  write request
- data_size  out  2  access size
- data_addr  out  32  byte address
- data_wstrb  out  4  byte strobes
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / write ack
- data_rdata  in  32  read data
- wait_cycles  out  WAIT_CNT_W  cycles spent in REQ+WAIT for the last mem op

Behaviour:
- Reset, resetn=0, asynchronous:
  - state=IDLE; out_valid=0; out_pc=RESET_PC.
  - out_result, out_dest, out_gr_we, out_ale, wait_cycles = 0.
  - All bus outputs are 0.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- in_ready = (state==IDLE | (state==HOLD & out_ready)) & !flush.
- Accept occurs when in_valid & in_ready. The payload is registered, and the next state is chosen as follows:
  - Non-mem op: HOLD with out_result=in_result. Latency is 1 cycle.
  - Mem op with misalignment (half & addr[0], or word & addr[1:0]!=0): HOLD with out_ale=1 and out_gr_we=0. No bus request is issued.
  - Aligned mem op: REQ.
- HOLD with out_ready and no new accept: IDLE.
- REQ:
  - data_req=1. Address, size, wr, wstrb and wdata are held stable until addr_ok.
  - wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
  - wdata: byte replicated x4, half replicated x2, word as-is.
  - On addr_ok: go to WAIT.
- WAIT, on data_ok:
  - Load: extract the lane by addr[1:0] and sign- or zero-extend per in_unsigned into out_result.
  - Store: out_result=in_result.
  - Go to HOLD; out_valid rises the next cycle.
  - data_ok in the same cycle as addr_ok is legal: REQ goes directly to HOLD.
- out_valid=1 only in HOLD. Payload is stable while out_valid & !out_ready.
- wait_cycles: cleared on entering REQ, increments each cycle in REQ/WAIT, saturates at all-ones, and is held otherwise.
- Flush:
  - IDLE/HOLD: go to IDLE; out_valid drops the next cycle.
  - REQ: data_req stays asserted until addr_ok, since requests are never withdrawn. Then go to DRAIN, or to IDLE if data_ok arrives in the same cycle.
  - WAIT: go to DRAIN, or to IDLE if data_ok arrives in the same cycle.
  - DRAIN: in_ready=0; out_valid=0. On data_ok go to IDLE, discarding the data.
- Flush overrides accept in the same cycle.
- data_ok outside WAIT/DRAIN (and REQ with addr_ok) is ignored.

Decomposition:
- Shared package (shared by EX/WB):
  - size encodings SZ_B/SZ_H/SZ_W;
  - state enum;
  - RESET_PC default.
- One sub-module, mem_lane_align: combinational strobe/wdata generation, load lane extraction and extension, and the misalignment check.

Test Plan:
- Non-mem op, in_result=0x12345678, out_ready=1 -> out_valid next cycle, out_result=0x12345678, no data_req.
- Load byte signed, addr=0x1003, addr_ok after 2 cycles, data_ok 3 cycles later, rdata=0x80FFFFFF -> out_result=0xFFFFFF80, wait_cycles=5 (counted from entering REQ). Same with in_unsigned=1 -> 0x00000080.
- Store half, addr=0x2002, rkd=0x0000BEEF -> data_wstrb=4'b1100, data_wdata=0xBEEFBEEF, data_wr=1; out_valid after data_ok.
- Load word, addr=0x3001 -> no data_req, out_ale=1, out_gr_we=0 the next cycle.
- Flush in WAIT, with data_ok 4 cycles later -> in_ready=0 and out_valid=0 throughout, return to IDLE after data_ok; next instruction accepted normally.
- out_ready=0 for 3 cycles in HOLD -> payload stable, in_ready=0; with out_ready=1 and in_valid the same cycle -> back-to-back accept.
- Assert resetn=0 mid-REQ -> data_req=0 and out_valid=0 immediately, without waiting for clk.
